// File: rtl/btn_press_gen.sv
// btn_press_gen: turns single-cycle request pulses into timed press waveforms
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   pulse_in   press request, one per cycle high
//   press_out  registered press level (HIGH_CYCLES high, then LOW_CYCLES low gap)
//   press_done one-cycle strobe in the first gap cycle
//   busy       press in progress or requests queued
//   pending    queued requests not yet started (saturating)
//   overflow   sticky, a request was dropped at saturation
module btn_press_gen #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 2,
    parameter int CNT_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic             press_out,
    output logic             press_done,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);
    localparam int MAXC = HIGH_CYCLES > LOW_CYCLES ? HIGH_CYCLES : LOW_CYCLES;
    localparam int TW   = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam logic [CNT_W-1:0] PMAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

    state_t           state, state_n;
    logic [TW-1:0]    timer, timer_n;
    logic [CNT_W-1:0] pending_n;
    logic             overflow_n, start, consume, queue, sat;

    always_comb begin
        state_n = state;
        timer_n = timer == '0 ? timer : timer - 1'b1;
        start   = 1'b0;
        case (state)
            IDLE: start = pulse_in || pending != '0;
            HIGH: if (timer == '0) begin
                state_n = GAP;
                timer_n = TW'(LOW_CYCLES - 1);
            end
            GAP: if (timer == '0) begin
                state_n = IDLE;
                start   = pulse_in || pending != '0;
            end
            default: state_n = IDLE;
        endcase
        if (start) begin
            state_n = HIGH;
            timer_n = TW'(HIGH_CYCLES - 1);
        end
        // queued requests win the start slot; a pulse that does not start a press is queued
        consume    = start && pending != '0;
        queue      = pulse_in && !(start && pending == '0);
        sat        = queue && !consume && pending == PMAX;
        pending_n  = queue && !consume && !sat ? pending + 1'b1 :
                     !queue && consume         ? pending - 1'b1 : pending;
        overflow_n = overflow || sat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            timer      <= '0;
            pending    <= '0;
            overflow   <= 1'b0;
            press_out  <= 1'b0;
            press_done <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            pending    <= pending_n;
            overflow   <= overflow_n;
            press_out  <= state_n == HIGH;
            press_done <= state == HIGH && timer == '0;
        end
    end

    assign busy = state != IDLE || pending != '0;
endmodule

// File: tb/tb_btn_press_gen.sv
// tb_btn_press_gen: directed table-driven bench for btn_press_gen
module tb_btn_press_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pulse_in = 1'b0;
    logic       press_out, press_done, busy, overflow;
    logic [1:0] pending;

    typedef struct {
        logic       p;
        logic       o;
        logic       d;
        logic       b;
        logic [1:0] n;
        logic       v;
    } vec_t;

    vec_t tbl[$];
    int   pass_cnt = 0;
    int   total = 0;

    btn_press_gen #(.HIGH_CYCLES(4), .LOW_CYCLES(2), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .press_out(press_out),
        .press_done(press_done), .busy(busy), .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic rows(input int k, input logic p, input logic o, input logic d,
                        input logic b, input logic [1:0] n, input logic v);
        vec_t r;
        r.p = p; r.o = o; r.d = d; r.b = b; r.n = n; r.v = v;
        repeat (k) tbl.push_back(r);
    endtask

    task automatic chk_all(input string tag, input logic o, input logic d, input logic b,
                           input logic [1:0] n, input logic v);
        chk({tag, " press_out"}, int'(press_out), int'(o));
        chk({tag, " press_done"}, int'(press_done), int'(d));
        chk({tag, " busy"}, int'(busy), int'(b));
        chk({tag, " pending"}, int'(pending), int'(n));
        chk({tag, " overflow"}, int'(overflow), int'(v));
    endtask

    initial begin
        #2;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // single press: high 1-4, done at 5, gap 5-6, idle from 7
        rows(1, 1, 0, 0, 0, 0, 0);
        rows(4, 0, 1, 0, 1, 0, 0);
        rows(1, 0, 0, 1, 1, 0, 0);
        rows(1, 0, 0, 0, 1, 0, 0);
        rows(2, 0, 0, 0, 0, 0, 0);
        // pulses at 0,1,2: presses 1-4, 7-10, 13-16
        rows(1, 1, 0, 0, 0, 0, 0);
        rows(1, 1, 1, 0, 1, 0, 0);
        rows(1, 1, 1, 0, 1, 1, 0);
        rows(2, 0, 1, 0, 1, 2, 0);
        rows(1, 0, 0, 1, 1, 2, 0);
        rows(1, 0, 0, 0, 1, 2, 0);
        rows(4, 0, 1, 0, 1, 1, 0);
        rows(1, 0, 0, 1, 1, 1, 0);
        rows(1, 0, 0, 0, 1, 1, 0);
        rows(4, 0, 1, 0, 1, 0, 0);
        rows(1, 0, 0, 1, 1, 0, 0);
        rows(1, 0, 0, 0, 1, 0, 0);
        rows(1, 0, 0, 0, 0, 0, 0);
        // pulse on last gap cycle with nothing queued: back-to-back press
        rows(1, 1, 0, 0, 0, 0, 0);
        rows(4, 0, 1, 0, 1, 0, 0);
        rows(1, 0, 0, 1, 1, 0, 0);
        rows(1, 1, 0, 0, 1, 0, 0);
        rows(4, 0, 1, 0, 1, 0, 0);
        rows(1, 0, 0, 1, 1, 0, 0);
        rows(1, 0, 0, 0, 1, 0, 0);
        rows(1, 0, 0, 0, 0, 0, 0);
        // pulse one cycle after the gap: one idle cycle, press 8-11
        rows(1, 1, 0, 0, 0, 0, 0);
        rows(4, 0, 1, 0, 1, 0, 0);
        rows(1, 0, 0, 1, 1, 0, 0);
        rows(1, 0, 0, 0, 1, 0, 0);
        rows(1, 1, 0, 0, 0, 0, 0);
        rows(4, 0, 1, 0, 1, 0, 0);
        rows(1, 0, 0, 1, 1, 0, 0);
        rows(1, 0, 0, 0, 1, 0, 0);
        rows(1, 0, 0, 0, 0, 0, 0);
        // pulses 0,2,6: pulse at 6 coincides with consume, pending stays 1
        rows(1, 1, 0, 0, 0, 0, 0);
        rows(1, 0, 1, 0, 1, 0, 0);
        rows(1, 1, 1, 0, 1, 0, 0);
        rows(2, 0, 1, 0, 1, 1, 0);
        rows(1, 0, 0, 1, 1, 1, 0);
        rows(1, 1, 0, 0, 1, 1, 0);
        rows(4, 0, 1, 0, 1, 1, 0);
        rows(1, 0, 0, 1, 1, 1, 0);
        rows(1, 0, 0, 0, 1, 1, 0);
        rows(4, 0, 1, 0, 1, 0, 0);
        rows(1, 0, 0, 1, 1, 0, 0);
        rows(1, 0, 0, 0, 1, 0, 0);
        rows(1, 0, 0, 0, 0, 0, 0);
        // pulse held 0-4: saturate at 3, overflow from 5, four presses
        rows(1, 1, 0, 0, 0, 0, 0);
        rows(1, 1, 1, 0, 1, 0, 0);
        rows(1, 1, 1, 0, 1, 1, 0);
        rows(1, 1, 1, 0, 1, 2, 0);
        rows(1, 1, 1, 0, 1, 3, 0);
        rows(1, 0, 0, 1, 1, 3, 1);
        rows(1, 0, 0, 0, 1, 3, 1);
        rows(4, 0, 1, 0, 1, 2, 1);
        rows(1, 0, 0, 1, 1, 2, 1);
        rows(1, 0, 0, 0, 1, 2, 1);
        rows(4, 0, 1, 0, 1, 1, 1);
        rows(1, 0, 0, 1, 1, 1, 1);
        rows(1, 0, 0, 0, 1, 1, 1);
        rows(4, 0, 1, 0, 1, 0, 1);
        rows(1, 0, 0, 1, 1, 0, 1);
        rows(1, 0, 0, 0, 1, 0, 1);
        rows(2, 0, 0, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            @(negedge clk);
            chk_all($sformatf("v%0d", i), tbl[i].o, tbl[i].d, tbl[i].b, tbl[i].n, tbl[i].v);
            pulse_in = tbl[i].p;
        end

        // asynchronous reset in the middle of a press with a request queued
        @(negedge clk);
        pulse_in = 1'b1;
        @(negedge clk);
        pulse_in = 1'b1;
        @(negedge clk);
        pulse_in = 1'b0;
        chk("pre-reset press_out", int'(press_out), 1);
        chk("pre-reset pending", int'(pending), 1);
        #2 rst = 1'b0;
        #1;
        chk_all("async rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("held rst", 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        pulse_in = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            pulse_in = 1'b0;
            chk($sformatf("post-rst c%0d press_out", c), int'(press_out), int'(c <= 4));
            chk($sformatf("post-rst c%0d press_done", c), int'(press_done), int'(c == 5));
            chk($sformatf("post-rst c%0d busy", c), int'(busy), int'(c <= 6));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/btn_press_gen.md
Name: btn_press_gen

Overview:
Converts single-cycle request pulses into timed, button-like press waveforms. It is the transmit-side counterpart to the board's press synchronizer. A press consists of a high level held for HIGH_CYCLES, followed by a mandatory low gap of LOW_CYCLES. Requests that arrive while a press is in progress are queued in a saturating pending counter, so no request is lost until the counter saturates. The block drives LEDs, external handshake lines, and loopback tests of the synchronizer path.

Parameters:
HIGH_CYCLES, 4, clocks the output is held high per press (must be >= 1)
LOW_CYCLES, 2, clocks of forced low gap after each press (must be >= 1)
CNT_W, 2, width of pending-request counter; max queued = 2^CNT_W - 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low
pulse_in  input  1  press request, one cycle per request
press_out  output  1  generated press level, registered
press_done  output  1  one-cycle strobe on the cycle press_out falls
busy  output  1  high when state != IDLE or pending != 0
pending  output  CNT_W  queued requests not yet started
overflow  output  1  sticky; set when a request is dropped at saturation

Behaviour:
- Reset (rst=0): takes effect immediately, without a clock edge. press_out=0, press_done=0, pending=0, overflow=0, state=IDLE, timer=0.
- States:
  - IDLE: press_out=0.
  - HIGH: press_out=1 for exactly HIGH_CYCLES cycles.
  - GAP: press_out=0 for exactly LOW_CYCLES cycles.
- IDLE -> HIGH: transition when pulse_in=1, or when pending>0.
  - Latency: pulse_in sampled high in cycle k gives press_out=1 in cycles k+1 .. k+HIGH_CYCLES.
- HIGH -> GAP: after the HIGH_CYCLES-th high cycle. press_out=0 and press_done=1 in the first GAP cycle only.
- GAP exit: on the last GAP cycle, if pending>0 or pulse_in=1, go directly to HIGH with no IDLE cycle. Otherwise go to IDLE. Press period is therefore HIGH_CYCLES+LOW_CYCLES.
- Start source priority: pending>0 is served first. A press started from pending decrements pending. A press started from pulse_in (only possible when pending=0) does not touch pending.
- pulse_in in any cycle where it does not directly start a press: pending increments.
- Simultaneous pulse_in and a start consumed from pending: pending unchanged.
- Saturation: pending at 2^CNT_W-1 with pulse_in=1 and no consume means pending holds and overflow is set. overflow is cleared only by reset.
- pulse_in held high for N cycles counts as N requests; there is no edge detection.
- busy is combinational from registered state and pending, with no extra latency.
- Timer width is sized from max(HIGH_CYCLES, LOW_CYCLES). The timer reloads on every state entry and never wraps inside a phase.
- Reset asserted mid-press: press_out drops to 0 immediately. The queue is flushed. No press_done is generated.

Test Plan:
(defaults HIGH=4, LOW=2, CNT_W=2)
1. Assert rst=0 mid-HIGH, with no clock edge -> press_out=0, pending=0, busy=0 immediately. After release, pulse_in at cycle 0 -> press_out=1 in cycles 1-4.
2. Single pulse_in at cycle 0 -> press_out=1 in cycles 1-4; press_done=1 in cycle 5 only; press_out=0 in cycles 5-6; busy=1 in cycles 1-6 and 0 from cycle 7.
3. pulse_in in cycles 0, 1, 2 -> press_out high in cycles 1-4, 7-10, 13-16. pending goes 1, 2 by cycle 3, then 1 at cycle 7, then 0 at cycle 13. overflow stays 0.
4. pulse_in held high in cycles 0-4 -> pending saturates at 3 after cycle 3; overflow=1 from cycle 5. Exactly 4 presses are produced (last ends at cycle 22); overflow remains 1 afterwards.
5. Single press, then pulse_in in cycle 6 (last GAP cycle, pending=0) -> press_out=1 in cycles 7-10 with no idle cycle between. Repeat with pulse_in in cycle 7 -> press_out=1 in cycles 8-11.
6. pulse_in in cycle 0 and again in cycle 6, with pending=1 at cycle 6 -> the pending request starts at cycle 7 and the new one queues (pending stays 1). A second press follows at cycles 13-16.
